input_unit_rc: RTL

- Per-input-port buffer and route-computation stage for the mesh router.
- Sits directly upstream of the switch allocator. One instance per router input (L, N, S, W).
- Accepts flits from the neighbour link or local core and stores each with an XY-routed one-hot output label.
- Presents the head flit and its label to the allocator, and pops the flit when the allocator grants it.

---
 rtl/input_unit_rc_if.sv | 29 ++
 rtl/input_unit_rc.sv | 106 ++++++++++
 2 files changed

// File: rtl/input_unit_rc_if.sv
// Bundle between the input unit, its upstream link and the switch allocator.
// Revision 1.0: initial release.
`default_nettype none

interface input_unit_rc_if #(
  parameter int DATASIZE = 40
);
  logic [DATASIZE-1:0] data_in;
  logic                data_valid_in;
  logic                full;
  logic [3:0]          label;
  logic                east_req;
  logic [DATASIZE-1:0] data_out;
  logic                ready;
  logic                route_err;
  logic                overflow_err;

  modport master (
    output data_in, data_valid_in, ready,
    input  full, label, east_req, data_out, route_err, overflow_err
  );

  modport slave (
    input  data_in, data_valid_in, ready,
    output full, label, east_req, data_out, route_err, overflow_err
  );
endinterface

`default_nettype wire

// File: rtl/input_unit_rc.sv
// input_unit_rc: per-port flit FIFO with XY route computation at write time.
// Optional HOP_STAMP_EN: saturating +1 on the head flit timestamp at the output. Revision 1.0.
`default_nettype none

module input_unit_rc #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40,
  parameter int CUR_X    = 0,
  parameter int CUR_Y    = 0,
  parameter int HAS_EAST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input_unit_rc_if.slave  bus
);

  localparam logic [1:0] c_cur_x = 2'(CUR_X);
  localparam logic [1:0] c_cur_y = 2'(CUR_Y);

  // Label field layout: bit4=E, bit3=L, bit2=N, bit1=S, bit0=W.
  logic [DATASIZE+4:0] r_mem [DEPTH];
  logic [WIDTH-1:0]    r_wr_ptr;
  logic [WIDTH-1:0]    r_rd_ptr;
  logic [WIDTH:0]      r_count;
  logic [DATASIZE-1:0] r_last;
  logic                r_route_err;
  logic                r_overflow_err;

  logic [1:0]          w_dst_x;
  logic [1:0]          w_dst_y;
  logic [4:0]          w_route;
  logic                w_route_bad;
  logic                w_push;
  logic                w_pop;
  logic                w_nonempty;
  logic [DATASIZE+4:0] w_head;
  logic [DATASIZE-1:0] w_head_out;

  assign w_dst_x = bus.data_in[35:34];
  assign w_dst_y = bus.data_in[33:32];

  always_comb begin
    w_route = 5'b01000;
    if (w_dst_x > c_cur_x)      w_route = 5'b10000;
    else if (w_dst_x < c_cur_x) w_route = 5'b00001;
    else if (w_dst_y > c_cur_y) w_route = 5'b00010;
    else if (w_dst_y < c_cur_y) w_route = 5'b00100;
  end

  assign w_route_bad = w_route[4] && (HAS_EAST == 0);
  assign bus.full    = (r_count == (WIDTH+1)'(DEPTH));
  assign w_push      = bus.data_valid_in && !bus.full && !w_route_bad;
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  assign bus.label    = w_nonempty ? w_head[DATASIZE+3:DATASIZE] : 4'b0000;
  assign bus.east_req = w_nonempty && w_head[DATASIZE+4];
  assign w_pop        = bus.ready && ((bus.label != 4'b0000) || bus.east_req);

  always_comb begin
    w_head_out = w_head[DATASIZE-1:0];
`ifdef HOP_STAMP_EN
    if (w_head[31:24] != 8'hFF)
      w_head_out[31:24] = w_head[31:24] + 8'd1;
`endif
  end

  // When empty, the last presented flit is held rather than exposing a stale slot.
  assign bus.data_out     = w_nonempty ? w_head_out : r_last;
  assign bus.route_err    = r_route_err;
  assign bus.overflow_err = r_overflow_err;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {w_route, bus.data_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_last         <= '0;
      r_route_err    <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_route_err    <= bus.data_valid_in && !bus.full && w_route_bad;
      r_overflow_err <= bus.data_valid_in && bus.full;
      if (w_nonempty)
        r_last <= w_head_out;
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == WIDTH'(DEPTH-1)) ? '0 : r_wr_ptr + WIDTH'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == WIDTH'(DEPTH-1)) ? '0 : r_rd_ptr + WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
